// File: rtl/program_loader_if.sv
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream handshake plus instruction-memory write port
//               shared by the boot loader and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: byte source and instruction memory.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Framed boot loader: sync, length, address, payload, checksum.
//               Writes instruction memory and holds the MCU until verified.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         ADDR_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    program_loader_if.slave            bus,
    input  wire logic                  reload,
    output logic [ADDR_WIDTH-1:0]      boot_pc,
    output logic                       mcu_hold,
    output logic                       done,
    output logic                       error
);

    localparam logic [2:0] c_SYNC  = 3'd0;
    localparam logic [2:0] c_LEN   = 3'd1;
    localparam logic [2:0] c_ADDR  = 3'd2;
    localparam logic [2:0] c_DATA  = 3'd3;
    localparam logic [2:0] c_CHECK = 3'd4;
    localparam logic [2:0] c_RUN   = 3'd5;
    localparam logic [2:0] c_ERR   = 3'd6;

    logic [2:0]            r_state;
    logic [8:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    logic [ADDR_WIDTH-1:0] r_boot_pc;
    logic [7:0]            r_csum;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;

    logic                  w_rx_ready;
    logic                  w_accept;

    assign w_rx_ready = (r_state != c_RUN) && (r_state != c_ERR);
    assign w_accept   = bus.rx_valid && w_rx_ready;

    assign bus.rx_ready  = w_rx_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // Status flags decode straight from the state so they all move on one edge.
    assign boot_pc  = r_boot_pc;
    assign mcu_hold = (r_state != c_RUN);
    assign done     = (r_state == c_RUN);
    assign error    = (r_state == c_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_SYNC;
            r_count     <= 9'd0;
            r_wptr      <= '0;
            r_pend_pc   <= '0;
            r_boot_pc   <= '0;
            r_csum      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_SYNC: begin
                    if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                        r_state <= c_LEN;
                    end
                end
                c_LEN: begin
                    if (w_accept) begin
                        // A length byte of zero encodes a full 256-byte payload.
                        r_count <= {(bus.rx_data == 8'd0), bus.rx_data};
                        r_state <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (w_accept) begin
                        r_wptr    <= ADDR_WIDTH'(bus.rx_data);
                        r_pend_pc <= ADDR_WIDTH'(bus.rx_data);
                        r_csum    <= 8'd0;
                        r_state   <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wptr;
                        r_mem_wdata <= bus.rx_data;
                        r_csum      <= r_csum + bus.rx_data;
                        r_wptr      <= r_wptr + 1'b1;
                        r_count     <= r_count - 9'd1;
                        if (r_count == 9'd1) begin
                            r_state <= c_CHECK;
                        end
                    end
                end
                c_CHECK: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_csum) begin
                            r_boot_pc <= r_pend_pc;
                            r_state   <= c_RUN;
                        end else begin
                            r_state   <= c_ERR;
                        end
                    end
                end
                c_RUN, c_ERR: begin
                    if (reload) begin
                        r_state <= c_SYNC;
                    end
                end
                default: r_state <= c_SYNC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time writer for the 8-bit MCU's instruction memory. It accepts a framed byte stream (sync, length, load address, payload, checksum), writes each payload byte into instruction memory at consecutive addresses, and holds the MCU core in reset until a frame passes its checksum. On success it releases the core with its reset PC equal to the frame's load address. It is the write side of the instruction-memory port that the MCU fetch path reads.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker; other bytes received while hunting are discarded.
- ADDR_WIDTH, 8, instruction memory address width; matches the MCU PC width.
- Clk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- reload  in  1  single-cycle pulse; restarts loading from RUN or ERR. Ignored in all other states.
- mem_we  out  1  instruction memory write enable; one cycle per payload byte.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  8  write data.
- boot_pc  out  ADDR_WIDTH  drives the MCU resetPC.
- mcu_hold  out  1  active-high hold; the MCU is in reset while this is 1.
- done  out  1  frame loaded and verified; core running.
- error  out  1  checksum mismatch; level until reload or reset.

## Operation
- States: SYNC, LEN, ADDR, DATA, CHECK, RUN, ERR.
- SYNC: accept bytes. A byte equal to SYNC_BYTE -> LEN; any other byte is dropped.
- LEN: the accepted byte is the payload count N. A value of 0 means 256. The count is held in a 9-bit register -> ADDR.
- ADDR: the accepted byte is the load address. It is latched into the write pointer and into the pending boot PC, and the checksum accumulator is cleared -> DATA.
- DATA: for each accepted byte, write the byte at the write pointer, add it to the 8-bit checksum (sum mod 256, carry discarded), increment the pointer, and decrement the count. After the Nth byte -> CHECK.
- Write-pointer wrap: 0xFF increments to 0x00. A 256-byte frame overwrites the whole memory.
- CHECK: the accepted byte is compared with the accumulated checksum.
  - Equal -> RUN: boot_pc takes the latched address, mcu_hold=0, done=1.
  - Not equal -> ERR: error=1, mcu_hold stays 1.
- RUN / ERR: rx_ready=0. A reload pulse returns to SYNC with mcu_hold=1, done=0, error=0. boot_pc keeps its last value.
- rx_ready=1 in SYNC, LEN, ADDR, DATA and CHECK. There is no backpressure within a frame, and rx_valid gaps of any length are allowed.
- reload is ignored in SYNC through CHECK. It does not abort a frame in progress.

## Timing
- Reset values: state=SYNC, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, boot_pc=0, mcu_hold=1, done=0, error=0.
- Asynchronous reset mid-frame discards the partial frame. Bytes already written stay in memory, and hunting restarts in SYNC.
- Write latency: a payload byte accepted at edge k gives mem_we=1 with its mem_addr and mem_wdata during the cycle after edge k.
  - mem_we is high for exactly one cycle per accepted payload byte.
  - mem_we is 0 when no payload byte was accepted on the previous edge.
- Checksum byte accepted at edge k: the state, mcu_hold, done, error and boot_pc updates are all visible after edge k, all changing on the same edge. mcu_hold falls on the same edge that done rises.
- reload sampled at edge k in RUN/ERR: mcu_hold=1 and rx_ready=1 after edge k.
- Minimum frame length is 4+N bytes, so 4+N cycles at full rate. The last memory write completes before mcu_hold falls.

## Test plan
- Nominal load: send A5, 03, 10, 11, 22, 33, 66.
  - Expect mem_we pulses at addresses 10/11/12 with data 11/22/33.
  - Then done=1, mcu_hold=0, boot_pc=8'h10, error=0.
- Bad checksum: send A5, 02, 00, 01, 02, 04.
  - Expect writes to 00/01, then error=1, mcu_hold=1, done=0.
  - A reload pulse clears error and rx_ready=1.
- Sync hunt and gaps: send 00, FF, 5A before A5, 01, 20, 7E, 7E, with rx_valid deasserted for 3 cycles between bytes.
  - Expect exactly one write (20<-7E) and done=1.
- Wrap and length 0: send A5, 00, FE, then 256 bytes of 01, then checksum 00.
  - Expect addresses FE, FF, 00 … FD, 256 mem_we pulses, and boot_pc=FE.
- Reset mid-frame: assert Reset low after 2 payload bytes.
  - Expect outputs at reset values immediately (asynchronous); a following complete frame loads normally.
- Reload from RUN: after a successful load, pulse reload, then send a new frame with address 40.
  - Expect mcu_hold=1 during loading and boot_pc=40 at done.
